// File: rtl/pu_riscv_verilog_pkg.sv
// Shared PU-RISCV definitions: access size encodings, memory fault cause bits
// and the pending data-memory access record.
package pu_riscv_verilog_pkg;

  localparam logic [2:0] BYTE  = 3'b000;
  localparam logic [2:0] HWORD = 3'b001;
  localparam logic [2:0] WORD  = 3'b010;
  localparam logic [2:0] DWORD = 3'b011;

  localparam int unsigned CAUSE_LD_MISALIGNED = 4;
  localparam int unsigned CAUSE_LD_PAGE_FAULT = 13;
  localparam int unsigned CAUSE_ST_MISALIGNED = 6;
  localparam int unsigned CAUSE_ST_PAGE_FAULT = 15;

  typedef struct packed {
    logic       we;
    logic [2:0] size;
    logic       uns;
    logic [2:0] adr;
    logic [4:0] rd;
    logic       killed;
  } dmem_pend_t;

endpackage

// File: rtl/pu_riscv_dmem_resp_fifo.sv
// In-order queue of outstanding data-memory accesses with a bulk-kill input
// that marks every stored entry as killed.
module pu_riscv_dmem_resp_fifo
  import pu_riscv_verilog_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  dmem_pend_t    din,
  input  logic          pop,
  input  logic          kill,
  output dmem_pend_t    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  dmem_pend_t       mem_q [DEPTH];
  logic [DEPTH-1:0] kill_q, kill_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot a full-queue push needs.
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    kill_d = kill_q;
    if (kill) kill_d = '1;
    if (push_ok) kill_d[wr_ptr_q] = din.killed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      kill_q   <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q  <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      kill_q <= kill_d;
    end
  end

  // Payload storage carries no reset; validity lives in the count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  always_comb begin
    dout        = mem_q[rd_ptr_q];
    dout.killed = kill_q[rd_ptr_q];
  end

endmodule

// File: rtl/pu_riscv_dmem_resp.sv
// Data-memory response stage: pairs acks with queued requests, aligns and
// extends load data, maps faults to causes and registers one write-back record.
module pu_riscv_dmem_resp
  import pu_riscv_verilog_pkg::*;
#(
  parameter int unsigned XLEN           = 64,
  parameter int unsigned EXCEPTION_SIZE = 16,
  parameter int unsigned DEPTH          = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      dmem_req,
  input  logic                      dmem_we,
  input  logic [2:0]                dmem_size,
  input  logic [XLEN-1:0]           dmem_adr,
  input  logic                      req_unsigned,
  input  logic [4:0]                req_rd,
  input  logic                      dmem_ack,
  input  logic [XLEN-1:0]           dmem_q,
  input  logic                      dmem_misaligned,
  input  logic                      dmem_page_fault,
  output logic                      resp_stall,
  output logic                      wb_valid,
  output logic                      wb_load,
  output logic [4:0]                wb_rd,
  output logic [XLEN-1:0]           wb_r,
  output logic [EXCEPTION_SIZE-1:0] wb_exception
);

  localparam int unsigned AW = $clog2(DEPTH);

  dmem_pend_t          push_ent, head;
  logic                full, empty, pop, record, fault, sgn;
  logic [AW:0]         count;
  logic [2:0]          sh;
  logic [XLEN-1:0]     shifted, fill, ld_data;
  logic [EXCEPTION_SIZE-1:0] exc;

  logic                      wb_valid_q, wb_load_q;
  logic [4:0]                wb_rd_q;
  logic [XLEN-1:0]           wb_r_q;
  logic [EXCEPTION_SIZE-1:0] wb_exc_q;

  always_comb begin
    push_ent        = '0;
    push_ent.we     = dmem_we;
    push_ent.size   = dmem_size;
    push_ent.uns    = req_unsigned;
    push_ent.adr    = dmem_adr[2:0];
    push_ent.rd     = req_rd;
    push_ent.killed = 1'b0;
  end

  pu_riscv_dmem_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (dmem_req),
    .din   (push_ent),
    .pop   (dmem_ack),
    .kill  (flush),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign pop        = dmem_ack && !empty;
  assign resp_stall = full && !dmem_ack;
  // An ack coinciding with flush belongs to a killed access.
  assign record     = pop && !head.killed && !flush;
  assign fault      = dmem_misaligned || dmem_page_fault;

  // Align then truncate/extend; DWORD passes the raw word through.
  always_comb begin
    sh      = (XLEN == 64) ? head.adr : {1'b0, head.adr[1:0]};
    shifted = dmem_q >> {sh, 3'b000};
    sgn     = 1'b0;
    fill    = '0;
    ld_data = dmem_q;
    case (head.size)
      BYTE: begin
        sgn     = ~head.uns & shifted[7];
        fill    = {XLEN{sgn}};
        ld_data = (fill << 8) | XLEN'(shifted[7:0]);
      end
      HWORD: begin
        sgn     = ~head.uns & shifted[15];
        fill    = {XLEN{sgn}};
        ld_data = (fill << 16) | XLEN'(shifted[15:0]);
      end
      WORD: begin
        sgn     = ~head.uns & shifted[31];
        fill    = {XLEN{sgn}};
        ld_data = (fill << 32) | XLEN'(shifted[31:0]);
      end
      default: ld_data = dmem_q;
    endcase
  end

  always_comb begin
    exc = '0;
    if (dmem_misaligned) begin
      if (head.we) exc[CAUSE_ST_MISALIGNED] = 1'b1;
      else         exc[CAUSE_LD_MISALIGNED] = 1'b1;
    end else if (dmem_page_fault) begin
      if (head.we) exc[CAUSE_ST_PAGE_FAULT] = 1'b1;
      else         exc[CAUSE_LD_PAGE_FAULT] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_load_q  <= 1'b0;
      wb_rd_q    <= '0;
      wb_r_q     <= '0;
      wb_exc_q   <= '0;
    end else begin
      wb_valid_q <= record;
      if (record) begin
        wb_load_q <= ~head.we;
        wb_rd_q   <= head.we ? 5'd0 : head.rd;
        wb_r_q    <= (head.we || fault) ? '0 : ld_data;
        wb_exc_q  <= exc;
      end
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_load      = wb_load_q;
  assign wb_rd        = wb_rd_q;
  assign wb_r         = wb_r_q;
  assign wb_exception = wb_exc_q;

endmodule
